// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between NREQ requesters, one transaction in flight at a time.
// Round-robin by default; define MEMARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module mem_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 20,
    parameter int DW   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    input  logic [NREQ-1:0]    wr,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic [NREQ-1:0]    err,
    output logic [NREQ-1:0]    gnt,
    output logic               mem_req,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    output logic               mem_wr,
    input  logic               mem_ack,
    input  logic [DW-1:0]      mem_rdata
);
    localparam int IW = $clog2(NREQ);
    localparam logic IDLE = 1'b0;
    localparam logic WAIT = 1'b1;

    logic            state;
    logic [IW-1:0]   last, own, win;
    logic [NREQ-1:0] pend, done, take, over;
    logic [AW-1:0]   slot_addr [NREQ];
    logic [DW-1:0]   slot_wdata [NREQ];
    logic [NREQ-1:0] slot_wr;

    // a slot freed by this edge's completion may be refilled in the same edge
    assign done = (state == WAIT && mem_ack) ? gnt : '0;
    assign take = req & (~pend | done);
    assign over = req & pend & ~done;

`ifdef MEMARB_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (pend[i]) win = IW'(i);
    end
`else
    logic [IW-1:0] idx;
    // scan from farthest to nearest so the first pending index after last wins
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (pend[idx]) win = idx;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            last      <= IW'(NREQ - 1);
            own       <= '0;
            pend      <= '0;
            err       <= '0;
            slot_wr   <= '0;
            ack       <= '0;
            rdata     <= '0;
            gnt       <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr    <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                slot_addr[i]  <= '0;
                slot_wdata[i] <= '0;
            end
        end else begin
            pend    <= (pend & ~done) | take;
            err     <= err | over;
            ack     <= done;
            mem_req <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (take[i]) begin
                    slot_addr[i]  <= addr[i*AW +: AW];
                    slot_wdata[i] <= wdata[i*DW +: DW];
                    slot_wr[i]    <= wr[i];
                end
            end
            if (state == IDLE && |pend) begin
                state     <= WAIT;
                own       <= win;
                gnt       <= NREQ'(1) << win;
                mem_req   <= 1'b1;
                mem_addr  <= slot_addr[win];
                mem_wdata <= slot_wdata[win];
                mem_wr    <= slot_wr[win];
            end else if (|done) begin
                state <= IDLE;
                last  <= own;
                gnt   <= '0;
                rdata <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus, a transaction-level reference model compared every cycle,
// and literal expectations for the service order, data and error flags.
module tb_mem_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 20;
    localparam int DW   = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*AW-1:0] addr = '0;
    logic [NREQ*DW-1:0] wdata = '0;
    logic [NREQ-1:0]    wr = '0;
    logic [NREQ-1:0]    ack, err, gnt;
    logic [DW-1:0]      rdata, mem_wdata;
    logic               mem_req, mem_wr;
    logic [AW-1:0]      mem_addr;
    logic               mem_ack = 1'b0;
    logic [DW-1:0]      mem_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata), .wr(wr),
        .ack(ack), .rdata(rdata), .err(err), .gnt(gnt),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return (a == 20'h12345) ? 16'hBEEF : a[15:0] ^ 16'h5A5A;
    endfunction

    // memory responder: acks lat cycles after each mem_req
    int lat = 3;
    logic [AW-1:0] resp_addr;
    always begin
        @(posedge clk);
        #1;
        if (mem_req) begin
            resp_addr = mem_addr;
            repeat (lat) @(negedge clk);
            mem_ack = 1'b1;
            mem_rdata = mem_val(resp_addr);
            @(negedge clk);
            mem_ack = 1'b0;
        end
    end

    // reference model: pending slots per requester, one owner in flight or -1
    bit              m_ok = 0;
    bit              m_pend [NREQ];
    logic [AW-1:0]   m_a [NREQ];
    logic [DW-1:0]   m_d [NREQ];
    bit              m_w [NREQ];
    int              m_owner = -1;
    int              m_last = NREQ - 1;
    int              mw;
    logic [NREQ-1:0] e_ack, e_err, e_gnt;
    logic [DW-1:0]   e_rdata, e_mwd;
    logic [AW-1:0]   e_maddr;
    logic            e_mreq, e_mwr;

    function automatic int pick();
`ifdef MEMARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (m_pend[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (m_pend[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
`endif
        return -1;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_ok = 1;
            m_owner = -1;
            m_last = NREQ - 1;
            for (int i = 0; i < NREQ; i++) begin
                m_pend[i] = 0; m_a[i] = '0; m_d[i] = '0; m_w[i] = 0;
            end
            e_ack = '0; e_err = '0; e_gnt = '0; e_rdata = '0;
            e_mreq = 0; e_mwr = 0; e_maddr = '0; e_mwd = '0;
        end else begin
            e_ack = '0;
            e_mreq = 0;
            if (m_owner < 0) begin
                mw = pick();
                if (mw >= 0) begin
                    m_owner = mw;
                    e_mreq = 1;
                    e_gnt = '0;
                    e_gnt[mw] = 1'b1;
                    e_maddr = m_a[mw];
                    e_mwd = m_d[mw];
                    e_mwr = m_w[mw];
                end
            end else if (mem_ack) begin
                e_ack[m_owner] = 1'b1;
                e_rdata = mem_val(e_maddr);
                m_pend[m_owner] = 0;
                m_last = m_owner;
                m_owner = -1;
                e_gnt = '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) begin
                    if (m_pend[i]) e_err[i] = 1'b1;
                    else begin
                        m_pend[i] = 1;
                        m_a[i] = addr[i*AW +: AW];
                        m_d[i] = wdata[i*DW +: DW];
                        m_w[i] = wr[i];
                    end
                end
            end
        end
    end

    // per-cycle comparison plus logs of acks and issued addresses
    int            ack_log [$];
    logic [AW-1:0] iss_addr [$];
    int            n_mreq = 0;
    always @(posedge clk) begin
        #1;
        if (m_ok) begin
            chk("ack", 32'(ack), 32'(e_ack));
            chk("rdata", 32'(rdata), 32'(e_rdata));
            chk("err", 32'(err), 32'(e_err));
            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("mem_req", 32'(mem_req), 32'(e_mreq));
            chk("mem_addr", 32'(mem_addr), 32'(e_maddr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e_mwd));
            chk("mem_wr", 32'(mem_wr), 32'(e_mwr));
            if (mem_req) begin
                n_mreq++;
                iss_addr.push_back(mem_addr);
            end
            for (int i = 0; i < NREQ; i++) if (ack[i]) ack_log.push_back(i);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic sample();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
        req = '0;
        req[i] = 1'b1;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
        wr[i] = w;
        @(negedge clk);
        req = '0;
    endtask

    task automatic pulse(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
        @(negedge clk);
        drive(i, a, d, w);
    endtask

    task automatic wait_ack(input logic [NREQ-1:0] m, input string name, output int n);
        n = 0;
        do begin
            sample();
            n++;
        end while ((ack & m) == 0 && n < 40);
        chk({name, " ack arrives"}, 32'((ack & m) != 0), 32'd1);
    endtask

    task automatic wait_log(input int cnt, input string name);
        int n = 0;
        while (ack_log.size() < cnt && n < 80) begin
            sample();
            n++;
        end
        chk({name, " ack count"}, 32'(ack_log.size()), 32'(cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        // reset with all requests raised
        req = '1;
        repeat (2) cyc();
        chk("reset gnt", 32'(gnt), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset rdata", 32'(rdata), 32'd0);
        rst = 1'b1;
        req = '0;
        repeat (4) cyc();
        chk("no capture during reset", 32'(n_mreq), 32'd0);

        // single read
        pulse(0, 20'h12345, 16'h0000, 1'b0);
        sample();
        chk("read mem_req", 32'(mem_req), 32'd1);
        chk("read mem_addr", 32'(mem_addr), 32'h12345);
        chk("read gnt", 32'(gnt), 32'b001);
        wait_ack(3'b001, "read", n);
        chk("read ack latency", 32'(n), 32'd3);
        chk("read ack", 32'(ack), 32'b001);
        chk("read rdata", 32'(rdata), 32'hBEEF);

        // single write
        pulse(2, 20'h00010, 16'hA55A, 1'b1);
        sample();
        chk("write mem_wr", 32'(mem_wr), 32'd1);
        chk("write mem_wdata", 32'(mem_wdata), 32'hA55A);
        chk("write gnt", 32'(gnt), 32'b100);
        wait_ack(3'b111, "write", n);
        chk("write ack", 32'(ack), 32'b100);

        // all three at once
        lat = 2;
        ack_log.delete();
        cyc();
        req = 3'b111;
        wr = '0;
        addr = {20'h00300, 20'h00200, 20'h00100};
        cyc();
        req = '0;
        wait_log(3, "contention");
        chk("contention order", 32'(ack_log[0] * 100 + ack_log[1] * 10 + ack_log[2]), 32'd12);

        // 0 re-requests exactly as it completes while 1 is waiting
        ack_log.delete();
        cyc();
        drive(0, 20'h00400, 16'h0000, 1'b0);
        drive(1, 20'h00500, 16'h0000, 1'b0);
        cyc();
        drive(0, 20'h00401, 16'h0000, 1'b0);
        wait_log(3, "priority");
`ifdef MEMARB_FIXED_PRIO_EN
        chk("priority order", 32'(ack_log[0] * 100 + ack_log[1] * 10 + ack_log[2]), 32'd1);
`else
        chk("priority order", 32'(ack_log[0] * 100 + ack_log[1] * 10 + ack_log[2]), 32'd10);
`endif
        chk("coincidence no err", 32'(err), 32'd0);

        // overrun: second request from 1 while the first is pending
        base = n_mreq;
        pulse(1, 20'h000A1, 16'h0000, 1'b0);
        pulse(1, 20'h000A2, 16'h0000, 1'b0);
        wait_ack(3'b010, "overrun", n);
        chk("overrun issued addr", 32'(iss_addr[$]), 32'h000A1);
        repeat (4) cyc();
        chk("overrun err", 32'(err), 32'b010);
        chk("overrun single issue", 32'(n_mreq - base), 32'd1);

        // request lands on the completion edge of its own transaction
        ack_log.delete();
        base = n_mreq;
        cyc();
        drive(1, 20'h000A3, 16'h0000, 1'b0);
        cyc();
        cyc();
        drive(1, 20'h000A4, 16'h0000, 1'b0);
        wait_log(2, "coincidence");
        chk("coincidence issues", 32'(n_mreq - base), 32'd2);
        chk("coincidence second addr", 32'(iss_addr[$]), 32'h000A4);
        chk("coincidence err kept", 32'(err), 32'b010);
        // request during the visible ack cycle
        req[1] = 1'b1;
        addr[AW +: AW] = 20'h000A5;
        sample();
        req = '0;
        wait_ack(3'b010, "ack-cycle req", n);
        chk("ack-cycle req addr", 32'(iss_addr[$]), 32'h000A5);
        chk("ack-cycle req err", 32'(err), 32'b010);

        // reset while waiting for memory; the late ack must be ignored
        lat = 6;
        repeat (3) cyc();
        base = ack_log.size();
        drive(0, 20'h00777, 16'h0000, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        repeat (8) cyc();
        chk("mid-op reset no ack", 32'(ack_log.size()), 32'(base));
        chk("mid-op reset gnt", 32'(gnt), 32'd0);
        chk("mid-op reset err", 32'(err), 32'd0);
        lat = 2;
        pulse(0, 20'h00888, 16'h0000, 1'b0);
        wait_ack(3'b001, "after reset", n);
        chk("after reset addr", 32'(iss_addr[$]), 32'h00888);
        chk("after reset rdata", 32'(rdata), 32'h52D2);
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
